// File: rtl/cm2_cell_pkg.sv
// Shared definitions for the CM2 cell BIST: op encoding, sequencer states,
// the reference gate function and the inert-input pad value.
package cm2_cell_pkg;

    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_XOR     = 3'd2;
    localparam logic [2:0] OP_NAND    = 3'd3;
    localparam logic [2:0] OP_NOR     = 3'd4;
    localparam logic [2:0] OP_XNOR    = 3'd5;
    localparam logic [2:0] OP_NOT     = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    // Wide enough for any fan-in encodable in a 3-bit arity
    localparam int GOLD_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} state_t;

    function automatic logic golden(input logic [2:0] op, input logic [2:0] arity,
                                    input logic [GOLD_W-1:0] vec);
        logic [GOLD_W-1:0] mask;
        logic [GOLD_W-1:0] v;
        logic              r;
        mask = (GOLD_W'(1) << arity) - GOLD_W'(1);
        v    = vec & mask;
        case (op)
            OP_AND, OP_NAND: r = &(v | ~mask);
            OP_OR,  OP_NOR:  r = |v;
            OP_XOR, OP_XNOR: r = ^v;
            default:         r = ~vec[0];
        endcase
        if (op == OP_NAND || op == OP_NOR || op == OP_XNOR) r = ~r;
        return r;
    endfunction

    function automatic logic pad_value(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_NAND);
    endfunction

endpackage

// File: rtl/cm2_cell_golden.sv
// Combinational golden model of a CM2 gate cell of the given op and fan-in.
module cm2_cell_golden
    import cm2_cell_pkg::*;
#(
    parameter int N_MAX = 6
) (
    input  logic [2:0]       op,
    input  logic [2:0]       arity,
    input  logic [N_MAX-1:0] vec,
    output logic             y
);

    assign y = golden(op, arity, GOLD_W'(vec));

endmodule

// File: rtl/cm2_cell_bist.sv
// Exhaustive-vector BIST sequencer for one CM2 gate cell: drives every input
// combination, compares against the golden model, counts and captures failures.
module cm2_cell_bist
    import cm2_cell_pkg::*;
#(
    parameter int N_MAX  = 6,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [2:0]       ARITY,
    output logic [N_MAX-1:0] DUT_IN,
    input  logic             DUT_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             CFG_ERR,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_VALID,
    output logic [N_MAX-1:0] FAIL_VEC
);

    // One spare bit so the all-ones vector of a full-width cell does not wrap
    localparam int VW = N_MAX + 1;

    state_t           state;
    logic [2:0]       op_q;
    logic [2:0]       ar_q;
    logic [VW-1:0]    vec;
    logic [3:0]       hold;
    logic [VW-1:0]    last_val;
    logic [N_MAX-1:0] stim;
    logic             cfg_ok;
    logic             sample;
    logic             gold_y;
    logic             mismatch;

    assign cfg_ok = (OP != OP_ILLEGAL) &&
                    ((OP == OP_NOT) || (ARITY >= 3'd2 && int'(ARITY) <= N_MAX));

    assign last_val = (VW'(1) << ar_q) - VW'(1);
    assign sample   = (state == S_HOLD) && (hold == 4'(SETTLE));
    assign mismatch = sample && (DUT_OUT != gold_y);

    always_comb begin
        stim = '0;
        for (int i = 0; i < N_MAX; i++)
            stim[i] = (i < int'(ar_q)) ? vec[i] : pad_value(op_q);
    end

    assign DUT_IN = (state == S_HOLD) ? stim : '0;

    cm2_cell_golden #(.N_MAX(N_MAX)) u_golden (
        .op    (op_q),
        .arity (ar_q),
        .vec   (vec[N_MAX-1:0]),
        .y     (gold_y)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            op_q       <= '0;
            ar_q       <= '0;
            vec        <= '0;
            hold       <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            CFG_ERR    <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VALID <= 1'b0;
            FAIL_VEC   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        DONE       <= 1'b0;
                        PASS       <= 1'b0;
                        CFG_ERR    <= 1'b0;
                        ERR_CNT    <= '0;
                        FAIL_VALID <= 1'b0;
                        vec        <= '0;
                        hold       <= '0;
                        if (cfg_ok) begin
                            state <= S_HOLD;
                            BUSY  <= 1'b1;
                            op_q  <= OP;
                            ar_q  <= (OP == OP_NOT) ? 3'd1 : ARITY;
                        end else begin
                            state   <= S_DONE;
                            DONE    <= 1'b1;
                            CFG_ERR <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    hold <= hold + 4'd1;
                    if (mismatch) begin
                        if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
                        if (!FAIL_VALID) begin
                            FAIL_VEC   <= stim;
                            FAIL_VALID <= 1'b1;
                        end
                    end
                    if (sample) begin
                        if (vec == last_val) begin
                            state <= S_DONE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            // a final-vector miss has not reached ERR_CNT yet
                            PASS  <= (ERR_CNT == '0) && !mismatch;
                        end else begin
                            vec  <= vec + 1'b1;
                            hold <= '0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cm2_cell_bist.md
# cm2_cell_bist

Built-in self-test sequencer for the CM2 primitive gate cells (NOT and the AND/OR/XOR/NAND/NOR/XNOR families, fan-in 2..6). It drives every input combination into one externally wired cell-under-test and compares the cell output against an internal golden model. It counts mismatches and captures the first failing vector. It sits beside the cell library in test builds and is controlled by a host or test harness through a START/DONE handshake.

## Interface
- N_MAX, 6: maximum cell fan-in, and the width of DUT_IN.
- SETTLE, 1: cycles each vector is held before the DUT output is sampled (legal range 1..15).
- ERR_W, 8: width of the mismatch counter.

- CLK  in  1  rising-edge clock.
- RST_N  in  1  reset, synchronous and active-low.
- START  in  1  single-cycle request to begin a run. Accepted only in IDLE or DONE.
- OP  in  3  cell type, sampled on START: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT, 7 illegal.
- ARITY  in  3  fan-in, sampled on START. Legal range 2..N_MAX. Ignored for NOT, which is forced to 1.
- DUT_IN  out  N_MAX  stimulus vector to the cell-under-test.
- DUT_OUT  in  1  output Y of the cell-under-test.
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  high from run end until the next accepted START.
- PASS  out  1  valid while DONE is high. 1 = zero mismatches and legal configuration.
- CFG_ERR  out  1  valid while DONE is high. 1 = illegal OP or ARITY.
- ERR_CNT  out  ERR_W  mismatch count, saturating.
- FAIL_VALID  out  1  FAIL_VEC holds a captured vector.
- FAIL_VEC  out  N_MAX  first mismatching vector.

## Operation
- States: IDLE, HOLD, DONE.
- IDLE or DONE, START=1:
  - Legal configuration → HOLD. vec=0, hold=0. ERR_CNT, FAIL_VALID, PASS and CFG_ERR are cleared. OP and ARITY are latched.
  - Illegal configuration → DONE with CFG_ERR=1 and PASS=0. No vectors are applied.
- HOLD:
  - hold increments every cycle.
  - When hold==SETTLE, DUT_OUT is compared with golden(OP, vec).
  - On a mismatch, ERR_CNT increments (saturating at 2^ERR_W−1). If FAIL_VALID=0, FAIL_VEC←DUT_IN and FAIL_VALID←1.
  - If vec == 2^arity−1 → DONE, with PASS = (no mismatch in this run). Otherwise vec+1 and hold=0.
- DONE: outputs hold until the next START. A START in DONE starts a new run directly.
- START while in HOLD is ignored. OP/ARITY changes during HOLD have no effect.
- DUT_IN composition:
  - Bits [arity−1:0] = vec.
  - Unused upper bits = 1 for AND/NAND and 0 for all other types, so the bits are inert for cells of larger fan-in.
  - In IDLE, DUT_IN = 0.
- Golden model: reduction over vec[arity−1:0]. NOT = ~vec[0].
- Vector counter width is clog2(N_MAX)+… ≥ N_MAX+1 bits, so the final vector does not wrap.

## Timing
- Reset values: state IDLE, DUT_IN=0, BUSY=0, DONE=0, PASS=0, CFG_ERR=0, ERR_CNT=0, FAIL_VALID=0, FAIL_VEC=0.
- START accepted at edge t:
  - BUSY=1 and DUT_IN=vector 0 from t+1.
  - Each vector is held SETTLE+1 cycles. DUT_OUT is sampled at the final edge of the hold.
- Run length is 2^arity·(SETTLE+1) cycles. DONE=1 and BUSY=0 in the cycle immediately following the last sample edge.
- Illegal configuration: DONE=1 and CFG_ERR=1 one cycle after START, with BUSY never asserted.
- RST_N low at any edge, including mid-run: all outputs return to their reset values at that edge, and the run is abandoned.
- A mismatch on the final vector is reflected in PASS and ERR_CNT in the same cycle DONE rises.

## Structure
- Package cm2_cell_pkg:
  - OP encoding constants (OP_AND..OP_NOT, OP_ILLEGAL).
  - State enum.
  - Function golden(op, arity, vec).
  - Function pad_value(op), which returns the unused-bit value.
- One sub-module, cm2_cell_golden: combinational golden model (op, arity, vec → y) wrapping the package function. It is reusable by the bench scoreboard.
- Top module holds the FSM, the hold and vector counters, and the error capture.

## Test plan
- AND_3 model, OP=0, ARITY=3, SETTLE=1 → 16 cycles BUSY. DUT_IN[5:3]=3'b111 throughout. DONE, PASS=1, ERR_CNT=0.
- XOR_6 model with output stuck at 0, OP=2, ARITY=6 → DONE after 128 cycles. ERR_CNT=32, FAIL_VEC=6'b000001, PASS=0.
- NOT model, OP=6, ARITY=5 (ignored) → exactly 2 vectors, 4 cycles BUSY. PASS=1. DUT_IN[5:1]=0.
- OP=7, or OP=0 with ARITY=1 → DONE and CFG_ERR=1 one cycle after START. BUSY never high. DUT_IN stays 0.
- ERR_W=4, NAND_6 model inverted → ERR_CNT saturates at 15 (not 64). FAIL_VEC=6'b000000.
- RST_N pulled low at cycle 10 of an OR_4 run → all outputs at reset values the next cycle. A new START runs cleanly to PASS=1.
